// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a start/busy/done handshake toward the execute stage.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] opnd_q;
  logic [AW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic            special_q;
  logic [XLEN-1:0] spec_res_q;
  logic            busy_q, done_q;
  logic [XLEN-1:0] result_q;

  logic            accept_c, finish_c;
  logic            a_signed_c, b_signed_c, a_neg_c, b_neg_c, neg_c;
  logic [XLEN-1:0] mag_a_c, mag_b_c;
  logic            div_zero_c, div_ovf_c, special_c;
  logic [XLEN-1:0] spec_res_c;

  assign accept_c = start && (state_q != S_CALC) && !flush;

  // Operand decode: signedness, magnitudes, final negate flag, divide corner cases
  always_comb begin
    a_signed_c = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed_c = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg_c    = a_signed_c && srca[XLEN-1];
    b_neg_c    = b_signed_c && srcb[XLEN-1];
    mag_a_c    = a_neg_c ? -srca : srca;
    mag_b_c    = b_neg_c ? -srcb : srcb;
    neg_c      = (funct3 == 3'b110) ? a_neg_c : (a_neg_c ^ b_neg_c);
    div_zero_c = funct3[2] && (srcb == '0);
    div_ovf_c  = funct3[2] && !funct3[0] && (srca == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (srcb == '1);
    special_c  = div_zero_c || div_ovf_c;
    spec_res_c = '0;
    if (div_zero_c) begin
      spec_res_c = funct3[1] ? srca : '1;
    end else if (div_ovf_c) begin
      spec_res_c = funct3[1] ? '0 : srca;
    end
  end

  // One iteration step for each algorithm and the sign-corrected final result
  logic [XLEN:0]   mul_sum_c, div_shift_c, div_diff_c;
  logic            div_ge_c;
  logic [AW-1:0]   step_c, prod_fix_c;
  logic [XLEN-1:0] div_raw_c, final_c;

  always_comb begin
    mul_sum_c   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift_c = acc_q[AW-2:XLEN-1];
    div_diff_c  = div_shift_c - {1'b0, opnd_q};
    div_ge_c    = !div_diff_c[XLEN];
    if (op_q[2]) begin
      step_c = {(div_ge_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0]),
                acc_q[XLEN-2:0], div_ge_c};
    end else begin
      step_c = {mul_sum_c, acc_q[XLEN-1:1]};
    end
    prod_fix_c = neg_q ? -acc_q : acc_q;
    div_raw_c  = op_q[1] ? acc_q[AW-1:XLEN] : acc_q[XLEN-1:0];
    if (op_q[2]) begin
      final_c = neg_q ? -div_raw_c : div_raw_c;
    end else if (op_q[1:0] == 2'b00) begin
      final_c = prod_fix_c[XLEN-1:0];
    end else begin
      final_c = prod_fix_c[AW-1:XLEN];
    end
  end

  assign finish_c = special_q || (cnt_q == CW'(XLEN));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c) state_d = S_CALC;
      S_CALC:  if (finish_c) state_d = S_DONE;
      S_DONE:  state_d = accept_c ? S_CALC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath: latch on accept, iterate in CALC, register result on entry to DONE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      busy_q <= (state_d == S_CALC);
      done_q <= (state_d == S_DONE);
      if (accept_c) begin
        op_q       <= funct3;
        opnd_q     <= funct3[2] ? mag_b_c : mag_a_c;
        acc_q      <= {{XLEN{1'b0}}, (funct3[2] ? mag_a_c : mag_b_c)};
        cnt_q      <= '0;
        neg_q      <= neg_c;
        special_q  <= special_c;
        spec_res_q <= spec_res_c;
      end else if (state_q == S_CALC && !flush) begin
        if (finish_c) begin
          result_q <= special_q ? spec_res_q : final_c;
        end else begin
          acc_q <= step_c;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
